// File: rtl/linx_uart_pkg.sv
// linx_uart_pkg: shared UART FIFO widths, default depth and status-register bit map
package linx_uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int LINX_UART_FIFO_DEPTH = 256;
  localparam int STS_EMPTY_BIT = 0;
  localparam int STS_FULL_BIT = 1;
  localparam int STS_OVERFLOW_BIT = 2;
  localparam int STS_COUNT_LSB = 8;
  localparam int STS_COUNT_W = $clog2(LINX_UART_FIFO_DEPTH) + 1;
endpackage

// File: rtl/linx_byte_ram.sv
// linx_byte_ram: DEPTH x byte storage, synchronous write, asynchronous read
module linx_byte_ram
  import linx_uart_pkg::*;
#(
  parameter int DEPTH = LINX_UART_FIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_BYTE_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_BYTE_W-1:0] o_rdata
);
  logic [UART_BYTE_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/linx_uart_tx_fifo.sv
// linx_uart_tx_fifo: lossless-capture byte FIFO from core UART to register block, with drop statistics
module linx_uart_tx_fifo
  import linx_uart_pkg::*;
#(
  parameter int DEPTH = LINX_UART_FIFO_DEPTH,
  parameter int OVF_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [UART_BYTE_W-1:0] in_byte,
  input  logic                   pop,
  output logic                   out_valid,
  output logic [UART_BYTE_W-1:0] out_byte,
  output logic [AW:0]            count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic [31:0]            byte_total
);
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;
  logic [OVF_W-1:0]       r_ovf_cnt;
  logic [31:0]            r_byte_total;
  logic                   w_empty, w_full, w_pop, w_push, w_drop;
  logic [UART_BYTE_W-1:0] w_head;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_pop   = pop & ~w_empty;
  // a full FIFO that is being popped frees a slot in the same cycle
  assign w_push  = in_valid & (~w_full | w_pop);
  assign w_drop  = in_valid & ~w_push;
  linx_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_push & ~flush & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_byte),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_ovf_cnt    <= '0;
      r_byte_total <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      r_wr_ptr     <= r_wr_ptr + AW'(w_push);
      r_rd_ptr     <= r_rd_ptr + AW'(w_pop);
      r_count      <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_byte_total <= r_byte_total + 32'(w_push);
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_ovf_cnt  <= &r_ovf_cnt ? r_ovf_cnt : r_ovf_cnt + 1'b1;
      end
    end
  end
  assign empty        = w_empty;
  assign full         = w_full;
  assign out_valid    = ~w_empty;
  assign out_byte     = w_empty ? '0 : w_head;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign overflow_cnt = r_ovf_cnt;
  assign byte_total   = r_byte_total;
endmodule

// File: tb/tb_linx_uart_tx_fifo.sv
// tb_linx_uart_tx_fifo: directed checks of the UART TX FIFO at DEPTH=4
module tb_linx_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, pop;
  logic [7:0]  in_byte;
  logic        out_valid, empty, full, overflow;
  logic [7:0]  out_byte;
  logic [2:0]  count;
  logic [15:0] overflow_cnt;
  logic [31:0] byte_total;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  linx_uart_tx_fifo #(.DEPTH(4), .OVF_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_byte(in_byte), .pop(pop),
    .out_valid(out_valid), .out_byte(out_byte), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .overflow_cnt(overflow_cnt), .byte_total(byte_total)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic p, input logic f);
    in_valid = v; in_byte = b; pop = p; flush = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_byte = 8'h00; pop = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ovf_cnt", overflow_cnt, 0);
    chk("rst_byte_total", byte_total, 0);
    cyc(0, 8'h00, 1, 0);
    chk("pop_empty_count", count, 0);
    cyc(0, 8'h00, 0, 1);
    chk("flush_empty_count", count, 0);
    cyc(1, 8'h41, 0, 0);
    chk("p1_count", count, 1);
    chk("p1_head", out_byte, 8'h41);
    chk("p1_valid", out_valid, 1);
    cyc(1, 8'h42, 0, 0);
    chk("p2_count", count, 2);
    chk("p2_head", out_byte, 8'h41);
    cyc(1, 8'h43, 0, 0);
    chk("p3_count", count, 3);
    cyc(0, 8'h00, 1, 0);
    chk("q1_count", count, 2);
    chk("q1_head", out_byte, 8'h42);
    cyc(0, 8'h00, 1, 0);
    chk("q2_count", count, 1);
    chk("q2_head", out_byte, 8'h43);
    cyc(0, 8'h00, 1, 0);
    chk("q3_count", count, 0);
    chk("q3_empty", empty, 1);
    chk("q3_head", out_byte, 0);
    chk("abc_byte_total", byte_total, 3);
    for (int i = 0; i < 6; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_cnt", overflow_cnt, 2);
    chk("ovf_byte_total", byte_total, 7);
    chk("ovf_head", out_byte, 8'h10);
    cyc(1, 8'h99, 1, 0);
    chk("fullpp_count", count, 4);
    chk("fullpp_ovf_cnt", overflow_cnt, 2);
    chk("fullpp_byte_total", byte_total, 8);
    chk("fullpp_head", out_byte, 8'h11);
    cyc(0, 8'h00, 1, 0);
    chk("drain_12", out_byte, 8'h12);
    cyc(0, 8'h00, 1, 0);
    chk("drain_13", out_byte, 8'h13);
    cyc(0, 8'h00, 1, 0);
    chk("drain_99", out_byte, 8'h99);
    cyc(0, 8'h00, 1, 0);
    chk("drain_empty", empty, 1);
    cyc(1, 8'h5a, 1, 0);
    chk("emptypp_count", count, 1);
    chk("emptypp_head", out_byte, 8'h5a);
    chk("emptypp_byte_total", byte_total, 9);
    cyc(0, 8'h00, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
    chk("pre_flush_count", count, 4);
    chk("pre_flush_ovf_cnt", overflow_cnt, 3);
    chk("pre_flush_total", byte_total, 13);
    cyc(1, 8'h77, 0, 1);
    chk("flush_count", count, 0);
    chk("flush_overflow", overflow, 0);
    chk("flush_ovf_cnt", overflow_cnt, 0);
    chk("flush_total", byte_total, 13);
    chk("flush_head", out_byte, 0);
    cyc(1, 8'h88, 0, 0);
    chk("post_flush_head", out_byte, 8'h88);
    chk("post_flush_count", count, 1);
    cyc(1, 8'h89, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_total", byte_total, 0);
    chk("midrst_head", out_byte, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'ha0 + 8'(i), 0, 0);
      chk($sformatf("wrap_head_%0d", i), out_byte, 8'ha0 + 8'(i));
      cyc(0, 8'h00, 1, 0);
    end
    chk("wrap_empty", empty, 1);
    chk("wrap_total", byte_total, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/linx_uart_tx_fifo.md
Name: linx_uart_tx_fifo

Overview:
Byte FIFO between the Linx core's UART output (uart_valid/uart_byte) and the AXI-Lite platform register block. The core cannot be back-pressured, so every byte it emits is captured here. The PS monitor drains the FIFO through a register read that pulses pop. The block reports occupancy, drop statistics and a lifetime byte count for the status registers.

Parameters:
DEPTH, 256, FIFO entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width (derived; not overridden).
OVF_W, 16, width of the saturating overflow (dropped-byte) counter.

Ports:
clk  in  1  single clock; aclk at platform level.
rst  in  1  synchronous, active-high reset.
flush  in  1  one-cycle pulse from regs; empties the FIFO.
in_valid  in  1  core UART byte strobe.
in_byte  in  8  core UART byte.
pop  in  1  one-cycle pulse from regs on a UART-data read; consumes the head.
out_valid  out  1  head byte present (equals ~empty).
out_byte  out  8  head byte; 8'h00 when empty.
count  out  AW+1  current occupancy, 0..DEPTH.
empty  out  1  count==0.
full  out  1  count==DEPTH.
overflow  out  1  sticky: at least one byte dropped since reset/flush.
overflow_cnt  out  OVF_W  number of dropped bytes; saturates at all-ones.
byte_total  out  32  bytes accepted since reset; wraps modulo 2^32; not cleared by flush.

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr, rd_ptr, count, overflow, overflow_cnt and byte_total all go to 0. Storage contents are don't-care.
- Outputs right after reset: empty=1, full=0, out_valid=0, out_byte=0.
- pop_eff = pop & ~empty. Evaluate against the pre-edge state.
- push_eff = in_valid & (~full | pop_eff).
  - A full FIFO with a simultaneous pop accepts the push.
  - An empty FIFO with a simultaneous pop+push ignores the pop. No bypass: the byte is stored and count becomes 1.
- On push_eff:
  - mem[wr_ptr] <= in_byte, wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
  - byte_total <= byte_total+1.
- On pop_eff: rd_ptr <= rd_ptr+1 (wraps mod DEPTH).
- count update: count + push_eff - pop_eff, so push+pop together leave it unchanged.
- Drop: in_valid & ~push_eff, which only happens when full and not popping.
  - overflow <= 1.
  - overflow_cnt <= overflow_cnt+1, holding at 2^OVF_W-1.
  - The FIFO state is unchanged.
- Latency:
  - A byte pushed at edge N is visible on out_byte/out_valid after edge N (first-word-fall-through from registered storage).
  - A pop at edge N exposes the next head after edge N.
- out_byte = empty ? 8'h00 : mem[rd_ptr]. This is an asynchronous read of the storage array; there is no combinational path from in_* to out_*.
- flush:
  - Pointers, count, overflow and overflow_cnt go to 0.
  - flush has priority over push/pop in the same cycle. A concurrent in_valid byte is discarded and counts neither toward overflow nor toward byte_total.
  - byte_total is preserved.
- rst has priority over flush.
- Reset mid-stream discards all buffered bytes. No partial state survives.
- pop or flush while empty: no effect beyond the flush clears.
- The core holding rst while in_valid=0 is normal; the FIFO is not tied to core_reset, only to platform rst.

Decomposition:
- Package linx_uart_pkg:
  - UART_BYTE_W=8.
  - LINX_UART_FIFO_DEPTH default.
  - Status-register bit positions consumed by linx_platform_regs_axi: empty, full, overflow, count field LSB/width.
- One sub-module: linx_byte_ram.
  - DEPTH x 8 storage, one synchronous write port, one asynchronous read port.
  - Kept separate so it can be swapped for distributed-RAM primitives.
  - Pointer/count/statistics logic stays in linx_uart_tx_fifo.

Test Plan:
- Reset then idle: empty=1, full=0, count=0, out_byte=0, overflow=0, byte_total=0.
- Push 0x41,0x42,0x43 on consecutive cycles, then pop three times:
  - Head reads 0x41, then 0x42, then 0x43, then empty=1.
  - count goes 1,2,3,2,1,0; byte_total=3.
- DEPTH=4 (override): push 6 bytes 0x10..0x15 with no pops:
  - full=1, count=4, overflow=1, overflow_cnt=2.
  - Drain yields 0x10..0x13 in order.
- Full FIFO, same cycle pop=1 and in_valid=1 with 0x99: count stays DEPTH, overflow_cnt unchanged, 0x99 emerges last after draining.
- Empty FIFO, same cycle pop=1 and in_valid=1 with 0x5A: count=1, out_byte=0x5A.
- 5 bytes buffered and overflow=1; assert flush together with in_valid (0x77):
  - count=0, overflow=0, overflow_cnt=0.
  - byte_total unchanged at its pre-flush value.
  - 0x77 is never observed.
- Push across the pointer wrap (DEPTH=4, 10 push/pop pairs): data order preserved and byte_total=10.
